// File: rtl/dragon_pkg.sv
// Shared types and helpers for the dragon shot collision detector.
package dragon_pkg;

  typedef enum logic {ARMED, COOLDOWN} dragon_hit_state_t;

  localparam int unsigned NUM_SHOTS_DEFAULT = 3;

  typedef logic [NUM_SHOTS_DEFAULT-1:0] shot_vec_t;

  // Bits needed to hold 0..frames, never less than one.
  function automatic int unsigned cnt_width(input int unsigned frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/frame_cooldown_counter.sv
// Frame-boundary down counter: loads a value, decrements on enabled frame
// boundaries unless frozen, and flags when it has reached zero.
module frame_cooldown_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             freeze_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !freeze_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dragon_shot_collision.sv
// Per-frame shot/dragon hit detector with frame-counted cooldown.
// Optional macro DRAGON_HIT_PRIORITY_EN reports only the lowest-index shot hit.
module dragon_shot_collision
  import dragon_pkg::*;
#(
  parameter int unsigned NUM_SHOTS       = NUM_SHOTS_DEFAULT,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned HITS_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  pause,
  input  logic                  dragonDrawReq,
  input  logic [NUM_SHOTS-1:0]  shotDrawReq,
  output logic [NUM_SHOTS-1:0]  shotDragonCollision,
  output logic                  dragonHit,
  output logic [HITS_WIDTH-1:0] hitCount,
  output logic                  cooldownActive
);

  localparam int unsigned CntW    = cnt_width(COOLDOWN_FRAMES);
  localparam int unsigned LoadInt = (COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0;
  localparam logic [CntW-1:0] LoadVal = CntW'(LoadInt);

  logic [NUM_SHOTS-1:0]  ovl, eval_set, report_vec;
  logic [NUM_SHOTS-1:0]  acc_q, acc_d;
  logic [NUM_SHOTS-1:0]  pulse_q, pulse_d;
  logic [HITS_WIDTH-1:0] count_q, count_d;
  dragon_hit_state_t     state_q, state_d;
  logic                  cnt_load, cnt_dec, cnt_zero;

  assign ovl      = shotDrawReq & {NUM_SHOTS{dragonDrawReq}};
  // The boundary clock's own overlap still belongs to the frame being closed.
  assign eval_set = acc_q | ovl;

`ifdef DRAGON_HIT_PRIORITY_EN
  assign report_vec = eval_set & (~eval_set + NUM_SHOTS'(1));
`else
  assign report_vec = eval_set;
`endif

  always_comb begin
    acc_d    = startOfFrame ? '0 : eval_set;
    pulse_d  = '0;
    count_d  = count_q;
    state_d  = state_q;
    cnt_load = 1'b0;
    if (startOfFrame && !pause) begin
      unique case (state_q)
        ARMED: begin
          if (eval_set != '0) begin
            pulse_d = report_vec;
            if (count_q != '1) count_d = count_q + HITS_WIDTH'(1);
            if (COOLDOWN_FRAMES > 0) begin
              state_d  = COOLDOWN;
              cnt_load = 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (cnt_zero) state_d = ARMED;
        end
      endcase
    end
  end

  assign cnt_dec = startOfFrame && (state_q == COOLDOWN) && !cnt_zero;

  frame_cooldown_counter #(
    .Width (CntW)
  ) u_cooldown_cnt (
    .clk_i      (clk),
    .rst_ni     (resetN),
    .load_i     (cnt_load),
    .load_val_i (LoadVal),
    .dec_i      (cnt_dec),
    .freeze_i   (pause),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      acc_q   <= '0;
      pulse_q <= '0;
      count_q <= '0;
      state_q <= ARMED;
    end else begin
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign shotDragonCollision = pulse_q;
  assign dragonHit           = |pulse_q;
  assign hitCount            = count_q;
  assign cooldownActive      = (state_q == COOLDOWN);

endmodule

// File: tb/tb_dragon_shot_collision.sv
// Bench for dragon_shot_collision: two instances (8-frame and zero cooldown)
// driven by shared stimulus and compared against a frame-level model.
module tb_dragon_shot_collision;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0;
  logic       pause = 1'b0;
  logic       drg = 1'b0;
  logic [2:0] shot = 3'b000;

  logic [2:0] a_col, b_col;
  logic       a_hit, b_hit, a_cool, b_cool;
  logic [7:0] a_cnt, b_cnt;
  logic [12:0] got_a, got_b;

  int checks = 0;
  int errors = 0;

  // Model state, one slot per instance: [0] cooldown 8, [1] cooldown 0.
  logic [2:0] m_acc[2];
  logic [2:0] m_pulse[2];
  int         m_cnt[2];
  int         m_cool[2];

  always #5 clk = ~clk;

  dragon_shot_collision #(
    .NUM_SHOTS       (3),
    .COOLDOWN_FRAMES (8),
    .HITS_WIDTH      (8)
  ) dut_a (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (sof),
    .pause               (pause),
    .dragonDrawReq       (drg),
    .shotDrawReq         (shot),
    .shotDragonCollision (a_col),
    .dragonHit           (a_hit),
    .hitCount            (a_cnt),
    .cooldownActive      (a_cool)
  );

  dragon_shot_collision #(
    .NUM_SHOTS       (3),
    .COOLDOWN_FRAMES (0),
    .HITS_WIDTH      (8)
  ) dut_b (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (sof),
    .pause               (pause),
    .dragonDrawReq       (drg),
    .shotDrawReq         (shot),
    .shotDragonCollision (b_col),
    .dragonHit           (b_hit),
    .hitCount            (b_cnt),
    .cooldownActive      (b_cool)
  );

  assign got_a = {a_col, a_hit, a_cnt, a_cool};
  assign got_b = {b_col, b_hit, b_cnt, b_cool};

  function automatic logic [2:0] rep(input logic [2:0] e);
`ifdef DRAGON_HIT_PRIORITY_EN
    for (int i = 0; i < 3; i++) if (e[i]) return 3'(1 << i);
    return 3'b000;
`else
    return e;
`endif
  endfunction

  function automatic logic [12:0] exp_vec(input int k);
    return {m_pulse[k], |m_pulse[k], 8'(m_cnt[k]), (m_cool[k] > 0)};
  endfunction

  // Frame-level model: m_cool counts frame boundaries still to be swallowed.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [2:0] e;
      int cd;
      cd = (k == 0) ? 8 : 0;
      e = m_acc[k] | (drg ? shot : 3'b000);
      m_pulse[k] = 3'b000;
      if (!resetN) begin
        m_acc[k] = 3'b000;
        m_cnt[k] = 0;
        m_cool[k] = 0;
      end else if (sof) begin
        m_acc[k] = 3'b000;
        if (!pause) begin
          if (m_cool[k] > 0) begin
            m_cool[k] = m_cool[k] - 1;
          end else if (e != 3'b000) begin
            m_pulse[k] = rep(e);
            if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
            m_cool[k] = cd;
          end
        end
      end else begin
        m_acc[k] = e;
      end
    end
  endtask

  task automatic tick(input logic s, input logic p, input logic d, input logic [2:0] sh);
    sof = s;
    pause = p;
    drg = d;
    shot = sh;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 3'b000);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 3'b111);
    tick(1'b1, 1'b0, 1'b1, 3'b111);
    checks++;
    if (got_a !== 13'd0) begin errors++; $display("FAIL reset_a got=%h exp=0", got_a); end
    checks++;
    if (got_b !== 13'd0) begin errors++; $display("FAIL reset_b got=%h exp=0", got_b); end
    resetN = 1'b1;
  endtask

  task automatic test_basic_hit();
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, 3'b010);
      checks++;
      if (a_col !== 3'b000) begin errors++; $display("FAIL no_sof_out got=%b exp=000", a_col); end
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0, 3'b000);
    tick(1'b1, 1'b0, 1'b0, 3'b000);
    checks++;
    if ({a_col, a_hit, a_cnt, a_cool} !== {3'b010, 1'b1, 8'd1, 1'b1}) begin
      errors++; $display("FAIL basic_pulse got=%h exp=%h", got_a, {3'b010, 1'b1, 8'd1, 1'b1});
    end
    checks++;
    if (got_b !== exp_vec(1)) begin errors++; $display("FAIL basic_b got=%h exp=%h", got_b, exp_vec(1)); end
    tick(1'b0, 1'b0, 1'b0, 3'b000);
    checks++;
    if ({a_col, a_hit, a_cool} !== {3'b000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL basic_one_clock got=%b%b%b exp=00001", a_col, a_hit, a_cool);
    end
  endtask

  task automatic test_multi_shot();
    logic [2:0] want;
`ifdef DRAGON_HIT_PRIORITY_EN
    want = 3'b001;
`else
    want = 3'b101;
`endif
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 3'b101);
    tick(1'b1, 1'b0, 1'b0, 3'b000);
    checks++;
    if (a_col !== want) begin errors++; $display("FAIL multi_a got=%b exp=%b", a_col, want); end
    checks++;
    if (b_col !== want) begin errors++; $display("FAIL multi_b got=%b exp=%b", b_col, want); end
  endtask

  task automatic test_periodic();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      repeat (2) tick(1'b0, 1'b0, 1'b1, 3'b001);
      tick(1'b1, 1'b0, 1'b0, 3'b000);
      checks++;
      if (a_hit !== (i == 1 || i == 10 || i == 19)) begin
        errors++; $display("FAIL periodic_a frame=%0d got=%b", i, a_hit);
      end
      checks++;
      if (got_b !== exp_vec(1)) begin
        errors++; $display("FAIL periodic_b frame=%0d got=%h exp=%h", i, got_b, exp_vec(1));
      end
    end
    checks++;
    if (a_cnt !== 8'd3) begin errors++; $display("FAIL periodic_count got=%0d exp=3", a_cnt); end
    checks++;
    if (b_cnt !== 8'd20) begin errors++; $display("FAIL periodic_count_b got=%0d exp=20", b_cnt); end
  endtask

  task automatic test_pause_cooldown();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      tick(1'b0, 1'b0, 1'b1, 3'b100);
      tick(1'b1, (i >= 3 && i <= 6), 1'b0, 3'b000);
      checks++;
      if ({a_hit, a_cool} !== {(i == 1 || i == 14), (i <= 12 || i >= 14)}) begin
        errors++;
        $display("FAIL pause_cd frame=%0d got hit=%b cool=%b", i, a_hit, a_cool);
      end
      checks++;
      if (got_a !== exp_vec(0)) begin
        errors++; $display("FAIL pause_cd_model frame=%0d got=%h exp=%h", i, got_a, exp_vec(0));
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_sof_overlap();
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 3'b100);
    checks++;
    if (a_col !== 3'b100) begin errors++; $display("FAIL sof_overlap got=%b exp=100", a_col); end
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 3'b010);
    tick(1'b0, 1'b0, 1'b1, 3'b010);
    tick(1'b1, 1'b1, 1'b1, 3'b010);
    checks++;
    if ({a_hit, b_hit} !== 2'b00) begin
      errors++; $display("FAIL paused_boundary got=%b%b exp=00", a_hit, b_hit);
    end
    tick(1'b1, 1'b0, 1'b0, 3'b000);
    checks++;
    if ({a_hit, b_hit} !== 2'b00) begin
      errors++; $display("FAIL acc_cleared got=%b%b exp=00", a_hit, b_hit);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      tick(1'b1, 1'b0, 1'b1, 3'b001);
      if (i == 254 || i == 255 || i == 260) begin
        checks++;
        if (b_cnt !== 8'((i < 255) ? i : 255)) begin
          errors++; $display("FAIL saturate hit=%0d got=%0d", i, b_cnt);
        end
      end
    end
    checks++;
    if (b_hit !== 1'b1) begin errors++; $display("FAIL sat_still_hits got=%b exp=1", b_hit); end
    resetN = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 3'b001);
    checks++;
    if ({got_a, got_b} !== 26'd0) begin
      errors++; $display("FAIL reset_mid_pulse got=%h %h exp=0", got_a, got_b);
    end
    resetN = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      resetN = ($urandom_range(0, 499) != 0);
      tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      checks++;
      if (got_a !== exp_vec(0)) begin
        errors++; $display("FAIL random_a step=%0d got=%h exp=%h", i, got_a, exp_vec(0));
      end
      checks++;
      if (got_b !== exp_vec(1)) begin
        errors++; $display("FAIL random_b step=%0d got=%h exp=%h", i, got_b, exp_vec(1));
      end
    end
    resetN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_multi_shot();
    test_periodic();
    test_pause_cooldown();
    test_sof_overlap();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
